// File: rtl/image_line_feeder.sv
// Streams a square frame out of frame memory in row-major order. It prefills the
// downstream line buffer and then sends one further line for each credit it receives.
module image_line_feeder #(
  parameter int F = 28,
  parameter int B = 8,
  localparam int AW = (F * F > 1) ? $clog2(F * F) : 1,
  localparam int CW = (F > 1) ? $clog2(F) : 1,
  localparam int RW = $clog2(F + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_intr,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  input  logic [B-1:0]  i_rd_data,
  output logic [B-1:0]  o_pixel_data,
  output logic          o_pixel_data_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int PRE_ROWS = (F < 4) ? F : 4;
  localparam logic [RW-1:0] ROWS         = RW'(F);
  localparam logic [RW-1:0] ROW_LAST_PRE = RW'(PRE_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST     = CW'(F - 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PREFILL     = 3'd1,
    S_SEND_LINE   = 3'd2,
    S_WAIT_CREDIT = 3'd3,
    S_FINISH      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [2:0]    credit_q, credit_d;
  logic          err_q, err_d;
  logic          rd_en_q, rd_en_d;
  logic          valid_q;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          start_s, consume_s, intr_ok_s;
  logic [RW-1:0] row_next_s;

  assign row_next_s = row_q + RW'(1);

  // Sequencing: which state comes next and where the read counters go.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = rd_en_q ? (addr_q + AW'(1)) : addr_q;
    done_d    = 1'b0;
    start_s   = 1'b0;
    consume_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          start_s = 1'b1;
          state_d = S_PREFILL;
          row_d   = {RW{1'b0}};
          col_d   = {CW{1'b0}};
          addr_d  = {AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREFILL, S_SEND_LINE: begin
        if (col_q == COL_LAST) begin
          col_d = {CW{1'b0}};
          row_d = row_next_s;
          if ((state_q == S_SEND_LINE) || (row_q == ROW_LAST_PRE)) begin
            state_d = (row_next_s < ROWS) ? S_WAIT_CREDIT : S_FINISH;
          end else begin
            state_d = state_q;
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      S_WAIT_CREDIT: begin
        if (credit_q != 3'd0) begin
          consume_s = 1'b1;
          state_d   = S_SEND_LINE;
        end else begin
          state_d = S_WAIT_CREDIT;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    rd_en_d = (state_d == S_PREFILL) || (state_d == S_SEND_LINE);
    busy_d  = (state_d != S_IDLE);
  end

  // Credits: once every row has been issued, further line grants have nothing to pay for.
  always_comb begin
    intr_ok_s = i_intr && (state_q != S_IDLE) && (row_q < ROWS);
    credit_d  = credit_q;
    err_d     = err_q;
    if (start_s) begin
      credit_d = 3'd0;
    end else if (intr_ok_s && !consume_s) begin
      if (credit_q == 3'd7) begin
        err_d = 1'b1;
      end else begin
        credit_d = credit_q + 3'd1;
      end
    end else if (consume_s && !intr_ok_s) begin
      credit_d = credit_q - 3'd1;
    end else begin
      credit_d = credit_q;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      row_q    <= {RW{1'b0}};
      col_q    <= {CW{1'b0}};
      addr_q   <= {AW{1'b0}};
      credit_q <= 3'd0;
      err_q    <= 1'b0;
      rd_en_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      addr_q   <= addr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      rd_en_q  <= rd_en_d;
      valid_q  <= rd_en_q;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_rd_en            = rd_en_q;
  assign o_rd_addr          = addr_q;
  assign o_pixel_data       = i_rd_data;
  assign o_pixel_data_valid = valid_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_image_line_feeder.sv
// Randomized bench for image_line_feeder. A burst-level reference model predicts every
// cycle's read strobe and address, pixel validity and data, busy, done and the error flag.
module tb_image_line_feeder;
  localparam int F    = 28;
  localparam int B    = 8;
  localparam int AW   = $clog2(F * F);
  localparam int P    = 4;
  localparam int NPIX = F * F;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_intr = 1'b0;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [B-1:0]  i_rd_data;
  logic [B-1:0]  o_pixel_data;
  logic          o_pixel_data_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  image_line_feeder #(.F(F), .B(B)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_intr(i_intr),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_pixel_data(o_pixel_data), .o_pixel_data_valid(o_pixel_data_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  logic [B-1:0] mem [NPIX];
  always @(posedge i_clk) if (o_rd_en) i_rd_data <= mem[o_rd_addr];

  int checks_n = 0;
  int fails_n  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      fails_n++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a prefill burst of P*F reads followed by F-read line
  // bursts, each one starting no earlier than two cycles after the previous burst and
  // two cycles after the credit that pays for it.
  bit mon_en = 1'b0;
  int cyc_n = 0;
  int m_busy = 0, m_burst_left = 0, m_rows_started = 0, m_addr = 0;
  int m_prev_rd = 0, m_prev_addr = 0, m_credit = 0, m_err = 0, m_done = 0;
  int m_all_issued = 0, m_finish_at = -1, m_rst_prev = 0, frame_pix = 0;

  always @(negedge i_clk) begin
    if (mon_en) begin
      int exp_rd, busy_c, intr_cnt, consume;
      exp_rd = (m_burst_left > 0) ? 1 : 0;
      check_eq("rd_en", o_rd_en, exp_rd);
      if (exp_rd != 0 || m_rst_prev != 0) check_eq("rd_addr", o_rd_addr, m_addr);
      check_eq("valid", o_pixel_data_valid, m_prev_rd);
      if (m_prev_rd != 0 && o_pixel_data_valid) check_eq("pixel", o_pixel_data, mem[m_prev_addr]);
      check_eq("busy", o_busy, m_busy);
      check_eq("done", o_done, m_done);
      check_eq("err", o_err, m_err);
      if (o_pixel_data_valid) frame_pix++;
      if (m_done != 0) check_eq("frame_pixels", frame_pix, NPIX);

      if (i_rst) begin
        m_busy = 0; m_burst_left = 0; m_rows_started = 0; m_addr = 0;
        m_prev_rd = 0; m_credit = 0; m_err = 0; m_done = 0;
        m_all_issued = 0; m_finish_at = -1; m_rst_prev = 1; frame_pix = 0;
      end else begin
        m_rst_prev = 0;
        busy_c   = m_busy;
        intr_cnt = (i_intr && m_busy != 0 && m_all_issued == 0) ? 1 : 0;
        consume  = (m_busy != 0 && exp_rd == 0 && m_rows_started < F && m_credit > 0) ? 1 : 0;
        m_prev_rd   = exp_rd;
        m_prev_addr = m_addr;
        m_done      = 0;
        if (exp_rd != 0) begin
          m_addr++;
          m_burst_left--;
          if (m_burst_left == 0 && m_rows_started == F) begin
            m_all_issued = 1;
            m_finish_at  = cyc_n + 2;
          end
        end
        if (consume != 0) begin
          m_burst_left = F;
          m_rows_started++;
        end
        if (intr_cnt != 0 && consume == 0) begin
          if (m_credit == 7) m_err = 1;
          else m_credit++;
        end else if (consume != 0 && intr_cnt == 0) begin
          m_credit--;
        end
        if (m_finish_at == cyc_n + 1) begin
          m_done = 1; m_busy = 0; m_finish_at = -1;
        end
        if (busy_c == 0 && i_start) begin
          m_busy = 1; m_burst_left = P * F; m_rows_started = P; m_addr = 0;
          m_credit = 0; m_all_issued = 0; frame_pix = 0;
        end
      end
      cyc_n++;
    end
  end

  task automatic cyc(input logic s, input logic it, input logic r);
    i_start = s; i_intr = it; i_rst = r;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_intr = 1'b0; i_rst = 1'b0;
  endtask

  function automatic logic rnd_intr(input int pct);
    return ($urandom_range(0, 99) < pct) && (m_credit <= 5);
  endfunction

  task automatic wait_done(input int budget, input int pct);
    int got = 0;
    for (int k = 0; k < budget; k++) begin
      if (o_done) begin got = 1; break; end
      cyc(($urandom_range(0, 19) == 0), rnd_intr(pct), 1'b0);
    end
    check_eq("done_reached", got, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int got;
    for (int i = 0; i < NPIX; i++) mem[i] = B'($urandom);
    @(posedge i_clk); #1;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    mon_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b1);

    // Prefill only, then stall with no credit; then a single credit, then the rest.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (150) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (40) cyc(1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 23; n++) begin
      for (int k = 0; k < 100 && m_credit > 5; k++) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      repeat ($urandom_range(0, 35)) cyc(($urandom_range(0, 9) == 0), 1'b0, 1'b0);
    end
    wait_done(2000, 0);
    repeat (5) cyc(1'b0, 1'b1, 1'b0);

    // Two credits during prefill.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (200) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);

    // Credit saturation with start requests while busy.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (8) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    repeat (150) cyc(1'b0, 1'b0, 1'b0);
    check_eq("err_sticky", o_err, 1);
    cyc(1'b0, 1'b0, 1'b1);

    // Reset at address 50 of prefill, colliding with start and credit.
    cyc(1'b1, 1'b0, 1'b0);
    got = 0;
    for (int k = 0; k < 200; k++) begin
      if (o_rd_en && o_rd_addr == AW'(50)) begin got = 1; break; end
      cyc(1'b0, 1'b0, 1'b0);
    end
    check_eq("addr50_reached", got, 1);
    cyc(1'b1, 1'b1, 1'b1);
    check_eq("post_reset_busy", o_busy, 0);
    cyc(1'b1, 1'b0, 1'b0);
    wait_done(3000, 6);
    cyc(1'b1, 1'b0, 1'b0);
    wait_done(3000, 8);

    // Random frames with an occasional mid-frame reset.
    for (int f = 0; f < 4; f++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (f == 1) begin
        repeat ($urandom_range(1, 400)) cyc(1'b0, rnd_intr(10), 1'b0);
        cyc(1'b0, 1'b0, 1'b1);
      end else begin
        wait_done(4000, $urandom_range(3, 40));
      end
      repeat ($urandom_range(0, 3)) cyc(1'b0, 1'b1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end
endmodule

// File: doc/image_line_feeder.md
IMAGE_LINE_FEEDER -- requirements
Module: image_line_feeder

Interface
REQ-001 Parameter F, default 28, meaning image width and height in pixels (square frame, F >= 1).
REQ-002 Parameter B, default 8, meaning pixel width in bits.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  one-cycle frame start request.
REQ-006 i_intr  input  1  one-cycle pulse from the downstream line-buffer controller, meaning one line was consumed; grants one row credit.
REQ-007 o_rd_en  output  1  frame-memory read strobe.
REQ-008 o_rd_addr  output  $clog2(F*F)  frame-memory read address, row-major (row*F + col).
REQ-009 i_rd_data  input  B  frame-memory read data, valid exactly one cycle after o_rd_en.
REQ-010 o_pixel_data  output  B  pixel to downstream, equal to i_rd_data.
REQ-011 o_pixel_data_valid  output  1  registered copy of o_rd_en delayed one cycle.
REQ-012 o_busy  output  1  high from start acceptance until o_done.
REQ-013 o_done  output  1  one-cycle pulse, frame fully sent.
REQ-014 o_err  output  1  sticky credit-overflow flag.

Function
REQ-015 States: IDLE, PREFILL, SEND_LINE, WAIT_CREDIT, FINISH; registered.
REQ-016 IDLE: o_rd_en=0; i_start=1 -> clear row/col counters, o_busy=1, go PREFILL; i_intr ignored.
REQ-017 PREFILL: o_rd_en=1 every cycle, addresses 0,1,2,... contiguous, for min(4,F) rows (4*F pixels at F>=4).
REQ-018 After prefill, rows remaining -> WAIT_CREDIT; none remaining -> FINISH.
REQ-019 WAIT_CREDIT: o_rd_en=0; credit>0 -> decrement credit, go SEND_LINE next cycle.
REQ-020 SEND_LINE: o_rd_en=1 for exactly F consecutive cycles, addresses row*F..row*F+F-1; at col=F-1 increment row; then WAIT_CREDIT if row<F else FINISH.
REQ-021 Credit counter 3 bits, cleared on start; +1 per i_intr in any state except IDLE.
REQ-022 i_intr in the same cycle as a credit consumption: net credit unchanged.
REQ-023 i_intr with credit=7: credit held at 7, o_err set until reset.
REQ-024 i_intr after all rows issued: ignored for credit, no error.
REQ-025 FINISH: waits one cycle for last o_pixel_data_valid, then o_done=1 for one cycle, o_busy=0, go IDLE.
REQ-026 i_start while o_busy=1 ignored; a new i_start in the o_done cycle is accepted next cycle from IDLE.
REQ-027 Column counter $clog2(F) bits wraps F-1 -> 0; row counter $clog2(F+1) bits; no address beyond F*F-1 ever driven with o_rd_en=1.
REQ-028 Latency: i_start at cycle 0 -> o_rd_en, addr 0 at cycle 1 -> o_pixel_data_valid at cycle 2; i_intr at cycle t with credit 0 in WAIT_CREDIT -> first o_rd_en at t+2.
REQ-029 Within one line o_pixel_data_valid has no gaps; gaps only between credited lines.

Reset
REQ-030 i_rst=1 -> state IDLE, counters 0, credit 0; o_rd_en, o_pixel_data_valid, o_busy, o_done, o_err all 0; o_rd_addr 0.
REQ-031 Reset mid-frame: next cycle all outputs at reset values; no o_done; no valid from the aborted read.
REQ-032 Reset dominates i_start and i_intr in the same cycle.

Verification
REQ-033 F=28, i_start -> 112 contiguous valid pixels, addresses 0..111, then o_rd_en=0 indefinitely with no i_intr.
REQ-034 After prefill, single i_intr -> 28 valid pixels, addresses 112..139, first o_rd_en 2 cycles after i_intr.
REQ-035 Two i_intr pulses during prefill -> lines 112..139 and 140..167 sent, one WAIT_CREDIT cycle between them.
REQ-036 24 i_intr after prefill -> final address 783, o_done one cycle after last valid, o_busy drops, 784 valid pixels total.
REQ-037 8 i_intr pulses during prefill -> credit saturates at 7, o_err=1 and held; i_start while busy ignored.
REQ-038 i_rst asserted at address 50 of prefill -> o_busy, o_rd_en, o_pixel_data_valid 0 next cycle; new i_start restarts at address 0.
